// File: rtl/pending_request_scheduler_pkg.sv
// Shared constants and width helpers for the pending-request scheduler.
package pending_request_scheduler_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Width of an index that can address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a count that can hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pending_request_scheduler_ffs.sv
// MSB-first find-first-set encoder: reports the highest set bit of in_vec.
module Find_First_Set_Bit #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan upward so the highest set bit is the last one to write idx.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_request_scheduler.sv
// Pending-request collector and strict MSB-first grant scheduler.
// Sticky pending bits feed a find-first-set encoder; the pick is registered
// into a one-entry valid/ready output stage and its pending bit is cleared.
// Optional duplicate-request detection: PENDING_REQUEST_SCHEDULER_OVERFLOW_EN.
module pending_request_scheduler
    import pending_request_scheduler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = idx_width(WIDTH),
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] req_set_i,
    input  logic             flush_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    input  logic             grant_ready_i,
    output logic [CNT_W-1:0] pending_count_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] clr_mask;
    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic             enc_valid;
    logic [IDX_W-1:0] enc_idx;
    logic             load;

    Find_First_Set_Bit #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_ffs (
        .in_vec (pending_q),
        .valid  (enc_valid),
        .idx    (enc_idx)
    );

    // The output stage accepts a new pick when empty or being drained.
    assign load = !valid_q || grant_ready_i;

    // Clear the picked bit; a same-cycle set on that bit re-arms it.
    always_comb begin
        clr_mask = '0;
        if (load && enc_valid) begin
            clr_mask[enc_idx] = 1'b1;
        end
        pending_next = (pending_q & ~clr_mask) | req_set_i;
    end

    // Pending register and output stage; flush discards everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else if (flush_i) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_next;
            if (load) begin
                valid_q <= enc_valid;
                if (enc_valid) begin
                    idx_q <= enc_idx;
                end
            end
        end
    end

    // Number of requesters still waiting (the held grant is not counted).
    always_comb begin
        pending_count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pending_count_o = pending_count_o + CNT_W'(pending_q[i]);
        end
    end

    assign grant_valid_o = valid_q;
    assign grant_idx_o   = idx_q;

`ifdef PENDING_REQUEST_SCHEDULER_OVERFLOW_EN
    logic overflow_q;
    logic dup_hit;

    // A set lands on a bit that is already waiting or is the stalled grant.
    always_comb begin
        dup_hit = |(req_set_i & pending_q);
        if (valid_q && !grant_ready_i && req_set_i[idx_q]) begin
            dup_hit = 1'b1;
        end
    end

    // Sticky flag, cleared only by reset or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q <= 1'b0;
        end else if (dup_hit) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_pending_request_scheduler.sv
// Directed testbench for pending_request_scheduler with a per-cycle model check.
module tb_pending_request_scheduler;
    import pending_request_scheduler_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int IW = idx_width(W);
    localparam int CW = cnt_width(W);
`ifdef PENDING_REQUEST_SCHEDULER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  req = '0;
    logic          flush = 1'b0;
    logic          ready = 1'b1;
    logic          gvalid;
    logic [IW-1:0] gidx;
    logic [CW-1:0] pcount;
    logic          ovf;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    pending_request_scheduler #(.WIDTH(W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_set_i       (req),
        .flush_i         (flush),
        .grant_valid_o   (gvalid),
        .grant_idx_o     (gidx),
        .grant_ready_i   (ready),
        .pending_count_o (pcount),
        .overflow_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [W-1:0] m_pend;
    bit         m_valid;
    int         m_idx;
    bit         m_ovf;
    bit [W-1:0] nx_pend;
    bit         nx_valid;
    int         nx_idx;
    bit         nx_ovf;

    function automatic int highest(input bit [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void model_next(
        input  bit [W-1:0] pend, input bit valid, input int idx, input bit ov,
        input  bit [W-1:0] set,  input bit fl,    input bit rdy,
        output bit [W-1:0] o_pend, output bit o_valid, output int o_idx, output bit o_ovf);
        int h;
        o_pend = pend; o_valid = valid; o_idx = idx; o_ovf = ov;
        if (fl) begin
            o_pend = '0; o_valid = 1'b0; o_ovf = 1'b0;
            return;
        end
        if (OVF_EN) begin
            if ((set & pend) != 0) o_ovf = 1'b1;
            if (valid && !rdy && set[idx]) o_ovf = 1'b1;
        end
        if (!valid || rdy) begin
            h = highest(pend);
            if (h >= 0) begin
                o_valid = 1'b1; o_idx = h; o_pend[h] = 1'b0;
            end else begin
                o_valid = 1'b0;
            end
        end
        o_pend = o_pend | set;
    endfunction

    always_comb model_next(m_pend, m_valid, m_idx, m_ovf, req, flush, ready,
                           nx_pend, nx_valid, nx_idx, nx_ovf);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= '0; m_valid <= 1'b0; m_idx <= 0; m_ovf <= 1'b0;
        end else begin
            m_pend <= nx_pend; m_valid <= nx_valid; m_idx <= nx_idx; m_ovf <= nx_ovf;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("model_valid", int'(gvalid), int'(m_valid));
            if (m_valid) check("model_idx", int'(gidx), m_idx);
            check("model_count", int'(pcount), $countones(m_pend));
            check("model_ovf", int'(ovf), int'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int v, input int i, input int c);
        check({name, "_valid"}, int'(gvalid), v);
        if (v != 0) check({name, "_idx"}, int'(gidx), i);
        check({name, "_count"}, int'(pcount), c);
    endtask

    initial begin
        // 1: reset state and idle
        #12;
        check("rst_valid", int'(gvalid), 0);
        check("rst_idx", int'(gidx), 0);
        check("rst_count", int'(pcount), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("idle_valid", int'(gvalid), 0);
        end
        $display("test idle done");

        // 2: three requests drain MSB-first
        req = 8'b1010_0100; ready = 1'b1;
        cyc(); req = '0;
        expect_out("burst0", 0, 0, 3);
        cyc(); expect_out("burst1", 1, 7, 2);
        cyc(); expect_out("burst2", 1, 5, 1);
        cyc(); expect_out("burst3", 1, 2, 0);
        cyc(); expect_out("burst4", 0, 0, 0);
        $display("test burst done");

        // 3: backpressure holds index stable
        req = 8'h80; ready = 1'b0;
        cyc(); req = '0;
        expect_out("bp0", 0, 0, 1);
        cyc(); expect_out("bp1", 1, 7, 0);
        req = 8'h40;
        cyc(); req = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(); expect_out("bp_hold", 1, 7, 1);
        end
        ready = 1'b1;
        cyc(); expect_out("bp_release", 1, 6, 0);
        cyc(); expect_out("bp_empty", 0, 0, 0);
        $display("test backpressure done");

        // 4: set/clear collision grants twice
        req = 8'h10;
        cyc(); expect_out("col0", 0, 0, 1);
        cyc(); req = '0;
        expect_out("col1", 1, 4, 1);
        cyc(); expect_out("col2", 1, 4, 0);
        cyc(); expect_out("col3", 0, 0, 0);
        $display("test collision done");

        // 5: flush wins over same-cycle set
        ready = 1'b0; req = 8'hFF;
        cyc(); req = '0;
        expect_out("fl0", 0, 0, 8);
        cyc(); expect_out("fl1", 1, 7, 7);
        flush = 1'b1; req = 8'h01;
        cyc(); flush = 1'b0; req = '0; ready = 1'b1;
        expect_out("fl2", 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); expect_out("fl_after", 0, 0, 0);
        end
        $display("test flush done");

        // 6: duplicate request sets the sticky overflow flag
        ready = 1'b0; req = 8'h08;
        cyc();
        check("ovf_first", int'(ovf), 0);
        cyc(); req = '0;
        check("ovf_set", int'(ovf), int'(OVF_EN));
        expect_out("ovf_grant", 1, 3, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(); check("ovf_hold", int'(ovf), int'(OVF_EN));
        end
        flush = 1'b1;
        cyc(); flush = 1'b0; ready = 1'b1;
        check("ovf_flush", int'(ovf), 0);
        expect_out("ovf_flush", 0, 0, 0);
        cyc();
        $display("test overflow done (enabled=%0d)", OVF_EN);

        // 7: asynchronous reset drops a held grant mid-cycle
        ready = 1'b0; req = 8'h01;
        cyc(); req = '0;
        cyc(); expect_out("ar0", 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", int'(gvalid), 0);
        check("ar_count", int'(pcount), 0);
        check("ar_ovf", int'(ovf), 0);
        @(negedge clk); rst_n = 1'b1; ready = 1'b1;
        #1;
        cyc(); expect_out("ar_after", 0, 0, 0);
        $display("test async reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
